fetch_ctrl: RTL

Fetch sequencer for the 4-stage core. It owns the fetch PC, issues at most one outstanding instruction-memory request, and delivers the returned instruction and its PC to decode under a stall handshake. It arbitrates the PC redirect sources (trap, mret, branch) and discards in-flight responses made stale by a redirect. It takes over PC-update duty, so the simple PC+4/branch mux is no longer needed in the fetch stage.

---
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner, single-outstanding imem requester, redirect arbiter.
// Optional trap/mret redirect ports: define FETCH_CTRL_TRAP_EN.
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_ctrl #(
  parameter logic [`DATA_WIDTH-1:0] RESET_VAL = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   br_valid_i,
  input  logic [`DATA_WIDTH-1:0] br_target_i,
`ifdef FETCH_CTRL_TRAP_EN
  input  logic                   trap_valid_i,
  input  logic [`DATA_WIDTH-1:0] trap_target_i,
  input  logic                   mret_valid_i,
  input  logic [`DATA_WIDTH-1:0] mret_target_i,
`endif
  input  logic                   stall_i,
  output logic                   imem_req_valid_o,
  output logic [`DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                   imem_req_ready_i,
  input  logic                   imem_rsp_valid_i,
  input  logic [`DATA_WIDTH-1:0] imem_rsp_data_i,
  output logic                   inst_valid_o,
  output logic [`DATA_WIDTH-1:0] inst_o,
  output logic [`DATA_WIDTH-1:0] inst_pc_o,
  output logic [`DATA_WIDTH-1:0] pc_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [`DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [`DATA_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [`DATA_WIDTH-1:0]   inst_q, inst_d;
  logic [`DATA_WIDTH-1:0]   inst_pc_q, inst_pc_d;
  logic                     inst_valid_q, inst_valid_d;

  logic                     redir;
  logic [`DATA_WIDTH-1:0]   redir_target;

`ifdef FETCH_CTRL_TRAP_EN
  assign redir        = trap_valid_i | mret_valid_i | br_valid_i;
  assign redir_target = trap_valid_i ? trap_target_i :
                        mret_valid_i ? mret_target_i : br_target_i;
`else
  assign redir        = br_valid_i;
  assign redir_target = br_target_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_VAL;
      req_pc_q     <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    unique case (state_q)
      S_REQ: begin
        if (imem_req_ready_i) begin
          if (redir) begin
            state_d = S_DROP;
          end else begin
            req_pc_d = pc_q;
            pc_d     = pc_q + `DATA_WIDTH'(4);
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (redir) begin
            state_d = S_REQ;
          end else begin
            inst_d       = imem_rsp_data_i;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_OUT;
          end
        end else if (redir) begin
          state_d = S_DROP;
        end
      end
      S_OUT: begin
        // A redirect flushes the held instruction instead of handing it over.
        if (redir || !stall_i) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect target overrides every other pc update.
    if (redir) begin
      pc_d = redir_target;
    end
  end

  assign imem_req_valid_o = (state_q == S_REQ) && !rst;
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign pc_o             = pc_q;

endmodule

`default_nettype wire
